// File: rtl/wave_decimator.sv
// wave_decimator: block-averaging decimator for the codec sample stream.
// Each block of 2^k input strobes produces one output strobe carrying the
// floor average of the block. k is taken from decim_sel (clamped to MAX_LOG2)
// only at block boundaries, so a mid-block change never produces a short block.
// Optional feature macro: PEAK_HOLD_EN adds a peak_mode input. When peak_mode
// is set, each block outputs its largest-magnitude sample instead of the average.
module wave_decimator #(
    parameter int MAX_LOG2 = 4,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_in_ready,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [2:0]       decim_sel,
`ifdef PEAK_HOLD_EN
    input  logic             peak_mode,
`endif
    output logic             new_sample,
    output logic [WIDTH-1:0] sample,
    output logic [2:0]       block_k
);

    localparam int         AW    = WIDTH + MAX_LOG2;
    localparam logic [2:0] MAX_K = 3'(MAX_LOG2);

    logic signed [AW-1:0]  acc_q, acc_d;
    logic [MAX_LOG2-1:0]   cnt_q, cnt_d;
    logic                  new_q, new_d;
    logic [WIDTH-1:0]      sample_q, sample_d;
    logic [2:0]            k_q, k_d;
    // Set during reset so the first edge after reset latches decim_sel.
    logic                  start_q, start_d;

    logic [2:0]            sel_k;
    logic [2:0]            eff_k;
    logic [MAX_LOG2:0]     last_cnt;
    logic                  is_last;
    logic signed [AW-1:0]  sum;

`ifdef PEAK_HOLD_EN
    logic [WIDTH-1:0]      peak_q, peak_d;
    logic                  mode_q, mode_d;
    logic                  eff_mode;
    logic [WIDTH-1:0]      cand;

    // Magnitude on WIDTH+1 bits so the most negative value is representable.
    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] e;
        e = {x[WIDTH-1], x};
        return e[WIDTH] ? (~e + 1'b1) : e;
    endfunction
`endif

    // Block bookkeeping: close detection, accumulation and output capture.
    always_comb begin
        sel_k    = (decim_sel > MAX_K) ? MAX_K : decim_sel;
        eff_k    = start_q ? sel_k : k_q;
        last_cnt = ((MAX_LOG2 + 1)'(1) << eff_k) - 1'b1;
        is_last  = ({1'b0, cnt_q} == last_cnt);
        sum      = acc_q + {{MAX_LOG2{sample_in[WIDTH-1]}}, sample_in};

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        new_d    = 1'b0;
        sample_d = sample_q;
        k_d      = eff_k;
        start_d  = 1'b0;
`ifdef PEAK_HOLD_EN
        eff_mode = start_q ? peak_mode : mode_q;
        mode_d   = eff_mode;
        peak_d   = peak_q;
        // Strict greater-than keeps the earliest sample on a magnitude tie.
        cand     = ((cnt_q == '0) || (mag(sample_in) > mag(peak_q))) ? sample_in : peak_q;
`endif

        if (sample_in_ready) begin
            if (is_last) begin
                acc_d    = '0;
                cnt_d    = '0;
                new_d    = 1'b1;
                sample_d = WIDTH'(sum >>> eff_k);
                k_d      = sel_k;
`ifdef PEAK_HOLD_EN
                if (eff_mode) begin
                    sample_d = cand;
                end
                mode_d   = peak_mode;
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
`ifdef PEAK_HOLD_EN
                peak_d = cand;
`endif
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            new_q    <= 1'b0;
            sample_q <= '0;
            k_q      <= sel_k;
            start_q  <= 1'b1;
`ifdef PEAK_HOLD_EN
            peak_q   <= '0;
            mode_q   <= peak_mode;
`endif
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            new_q    <= new_d;
            sample_q <= sample_d;
            k_q      <= k_d;
            start_q  <= start_d;
`ifdef PEAK_HOLD_EN
            peak_q   <= peak_d;
            mode_q   <= mode_d;
`endif
        end
    end

    assign new_sample = new_q;
    assign sample     = sample_q;
    assign block_k    = k_q;

endmodule
